btn_conditioner: RTL

//   Front end for the player-movement stage. Synchronises and debounces the four raw

---
 rtl/pacman_pkg.sv | 22 ++
 rtl/debounce_cell.sv | 53 +++++
 rtl/btn_conditioner.sv | 59 +++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared direction constants and the L > U > R > D priority selector used by
// the button front end, the movement stage and the direction-flag logic.
package pacman_pkg;

  localparam logic [3:0] DIR_L    = 4'b1000;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_D    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  // Highest-priority set bit of req as a one-hot direction, or DIR_NONE.
  function automatic logic [3:0] dir_priority(input logic [3:0] req);
    logic [3:0] sel;
    sel = DIR_NONE;
    if      (req[3]) sel = DIR_L;
    else if (req[2]) sel = DIR_U;
    else if (req[1]) sel = DIR_R;
    else if (req[0]) sel = DIR_D;
    return sel;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: SYNC_STAGES-deep synchroniser followed by a debounce counter.
// The stable level only changes after the synchronised level has differed
// from it for DEBOUNCE_CYCLES consecutive edges.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;

  assign s        = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;

  // Next-state: shift the synchroniser; count while s disagrees with the stable level.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: four debounce cells, rising-edge press detection and the
// arbitration register that turns held buttons into a one-hot direction.
module btn_conditioner
  import pacman_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_stable,
  output logic [3:0] press_pulse,
  output logic [3:0] btn
);

  logic [3:0] stable_d_q;
  logic [3:0] btn_q, btn_d;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_cell (
      .clk_i    (clk_50mhz),
      .rst_ni   (rst_n),
      .raw_i    (btn_raw[g]),
      .stable_o (btn_stable[g])
    );
  end

  assign press_pulse = btn_stable & ~stable_d_q;
  assign btn         = btn_q;

  // Arbitration: newest press wins; on release of the selected button fall
  // back to the highest-priority button still held.
  always_comb begin
    btn_d = btn_q;
    if (press_pulse != DIR_NONE) begin
      btn_d = dir_priority(press_pulse);
    end else if (btn_q != DIR_NONE && (btn_q & btn_stable) == DIR_NONE) begin
      btn_d = dir_priority(btn_stable);
    end
  end

  // Delayed stable copy and arbitration register.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      stable_d_q <= '0;
      btn_q      <= DIR_NONE;
    end else begin
      stable_d_q <= btn_stable;
      btn_q      <= btn_d;
    end
  end

endmodule
